// File: rtl/mod_step_counter.sv
// Programmable-modulus step counter: wrap/saturate, synchronous load, terminal-count pulse, sticky boundary flag.
// Latency: value and flags update one clock edge after inputs are sampled; no combinational input-to-output paths.
// Backpressure: none; Enable gates counting (optional prescaler via `define MOD_STEP_COUNTER_PRESCALE_EN).
module mod_step_counter #(
  parameter int WIDTH      = 8,
  parameter int STEP_WIDTH = 4,
  parameter int PRESCALE   = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  Enable,
  input  logic                  UP_DOWN,
  input  logic                  Mode,
  input  logic [STEP_WIDTH-1:0] Step,
  input  logic [WIDTH-1:0]      Limit,
  input  logic                  Load,
  input  logic [WIDTH-1:0]      Load_Value,
  input  logic                  Clear_Flag,
  output logic [WIDTH-1:0]      value,
  output logic                  Terminal_Count,
  output logic                  Boundary_Flag
);

  // One extra bit so sums near 2^WIDTH never overflow silently.
  localparam int EW = WIDTH + 1;

  if (STEP_WIDTH < 1 || STEP_WIDTH > WIDTH || PRESCALE < 1) begin : g_param_err
    $error("mod_step_counter: invalid parameter combination");
  end

  logic [WIDTH-1:0] r_value;
  logic             r_tc;
  logic             r_flag;

  logic [EW-1:0]    w_val_x;
  logic [EW-1:0]    w_step_x;
  logic [EW-1:0]    w_lim_x;
  logic [EW-1:0]    w_lim_p1;
  logic [EW-1:0]    w_up_sum;
  logic [EW-1:0]    w_up_wrap;
  logic [EW:0]      w_dn_full;
  logic [WIDTH-1:0] w_dn_sub;
  logic [WIDTH-1:0] w_up_wrap_v;
  logic [WIDTH-1:0] w_dn_wrap_v;
  logic [WIDTH-1:0] w_next;
  logic             w_event;
  logic             w_tick;
  logic             w_count;

  assign w_val_x  = {1'b0, r_value};
  assign w_step_x = EW'(Step);
  assign w_lim_x  = {1'b0, Limit};
  assign w_lim_p1 = w_lim_x + EW'(1);
  assign w_up_sum = w_val_x + w_step_x;
  // Only used when w_up_sum > Limit, so it never underflows.
  assign w_up_wrap = w_up_sum - w_lim_p1;
  // value + (Limit+1) - Step; top bit flags a borrow when Step is oversized.
  assign w_dn_full = {1'b0, w_val_x} + {1'b0, w_lim_p1} - {1'b0, w_step_x};
  assign w_dn_sub  = r_value - w_step_x[WIDTH-1:0];

  // Oversized steps (Step > Limit+1) are a caller error; fall back to 0 so the
  // value stays in range. This also keeps Limit=0 pinned at 0.
  assign w_up_wrap_v = (w_up_wrap <= w_lim_x) ? w_up_wrap[WIDTH-1:0] : '0;
  assign w_dn_wrap_v = (!w_dn_full[EW] && (w_dn_full[EW-1:0] <= w_lim_x))
                       ? w_dn_full[WIDTH-1:0] : '0;

`ifdef MOD_STEP_COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_pre;
  logic          w_pre_last;

  assign w_pre_last = (r_pre == PW'(PRESCALE - 1));
  assign w_tick     = Enable & w_pre_last;

  // Prescaler: counts enabled cycles, restarts on Load, frozen while Enable=0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre <= '0;
    end else if (Load) begin
      r_pre <= '0;
    end else if (Enable) begin
      r_pre <= w_pre_last ? '0 : r_pre + PW'(1);
    end
  end
`else
  assign w_tick = Enable;
`endif

  assign w_count = w_tick & ~Load & (Step != '0);

  // Next-value and boundary-event decode for one counting step.
  always_comb begin
    w_next  = r_value;
    w_event = 1'b0;
    if (w_val_x > w_lim_x) begin
      // Out-of-range start (overload or lowered Limit) snaps to the bound.
      w_next  = UP_DOWN ? '0 : Limit;
      w_event = 1'b1;
    end else if (UP_DOWN) begin
      if (w_up_sum <= w_lim_x) begin
        w_next = w_up_sum[WIDTH-1:0];
      end else begin
        w_next  = Mode ? Limit : w_up_wrap_v;
        w_event = 1'b1;
      end
    end else begin
      if (w_val_x >= w_step_x) begin
        w_next = w_dn_sub;
      end else begin
        w_next  = Mode ? '0 : w_dn_wrap_v;
        w_event = 1'b1;
      end
    end
  end

  // Counter state, terminal-count pulse and sticky flag (set beats clear).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_value <= '0;
      r_tc    <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      if (Load) begin
        r_value <= Load_Value;
      end else if (w_count) begin
        r_value <= w_next;
      end
      r_tc   <= w_count & w_event;
      r_flag <= (w_count & w_event) | (r_flag & ~Clear_Flag);
    end
  end

  assign value          = r_value;
  assign Terminal_Count = r_tc;
  assign Boundary_Flag  = r_flag;

endmodule

// File: tb/tb_mod_step_counter.sv
// Directed-vector bench for mod_step_counter with an expected-response queue.
// Driver pushes hand-computed results; a monitor pops and compares one cycle later.
// Async reset is checked directly between clock edges.
module tb_mod_step_counter;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       Enable = 1'b0;
  logic       UP_DOWN = 1'b0;
  logic       Mode = 1'b0;
  logic [3:0] Step = '0;
  logic [7:0] Limit = '0;
  logic       Load = 1'b0;
  logic [7:0] Load_Value = '0;
  logic       Clear_Flag = 1'b0;
  logic [7:0] value;
  logic       Terminal_Count;
  logic       Boundary_Flag;

  mod_step_counter #(.WIDTH(8), .STEP_WIDTH(4), .PRESCALE(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .Enable(Enable), .UP_DOWN(UP_DOWN), .Mode(Mode),
    .Step(Step), .Limit(Limit), .Load(Load), .Load_Value(Load_Value),
    .Clear_Flag(Clear_Flag), .value(value), .Terminal_Count(Terminal_Count),
    .Boundary_Flag(Boundary_Flag)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic [7:0] v;
    logic       tc;
    logic       f;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   vid = 0;

  task automatic check(input string nm, input int id, input logic [7:0] v,
                       input logic tc, input logic f, input logic [7:0] ev,
                       input logic etc, input logic ef);
    checks++;
    if (v !== ev || tc !== etc || f !== ef) begin
      errors++;
      $display("FAIL %s #%0d: got value=%0d tc=%0b flag=%0b, expected value=%0d tc=%0b flag=%0b",
               nm, id, v, tc, f, ev, etc, ef);
    end
  endtask

  // Monitor: one expected entry per clock edge, sampled just after the edge.
  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("vec", e.id, value, Terminal_Count, Boundary_Flag, e.v, e.tc, e.f);
    end
  end

  // Apply one cycle of inputs and queue the state expected after the next edge.
  task automatic cyc(input logic en, input logic up, input logic md,
                     input logic [3:0] st, input logic [7:0] lim,
                     input logic ld, input logic [7:0] lv, input logic clr,
                     input logic [7:0] ev, input logic etc, input logic ef);
    @(negedge CLK);
    Enable = en; UP_DOWN = up; Mode = md; Step = st; Limit = lim;
    Load = ld; Load_Value = lv; Clear_Flag = clr;
    q.push_back('{vid, ev, etc, ef});
    vid++;
  endtask

  task automatic drain();
    int n;
    @(negedge CLK);
    Enable = 1'b0; Load = 1'b0; Clear_Flag = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge CLK);
      #2;
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("reset_init", 0, value, Terminal_Count, Boundary_Flag, 8'd0, 1'b0, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

`ifdef MOD_STEP_COUNTER_PRESCALE_EN
    // Step=1, Enable held: value moves only every 4th enabled cycle.
    cyc(1,1,0,1,9,0,0,0, 8'd0,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd0,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd0,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd1,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd1,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd1,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd1,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd2,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd2,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd2,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd2,0,0);
    cyc(1,1,0,1,9,0,0,0, 8'd3,0,0);
    drain();
`else
    // Count to 5, then async reset between edges.
    cyc(1,1,0,5,9,0,0,0, 8'd5,0,0);
    drain();
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("reset_mid", 0, value, Terminal_Count, Boundary_Flag, 8'd0, 1'b0, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Wrap up: Limit=9, Step=3.
    cyc(1,1,0,3,9,0,0,0, 8'd3,0,0);
    cyc(1,1,0,3,9,0,0,0, 8'd6,0,0);
    cyc(1,1,0,3,9,0,0,0, 8'd9,0,0);
    cyc(1,1,0,3,9,0,0,0, 8'd2,1,1);
    cyc(0,1,0,3,9,0,0,0, 8'd2,0,1);
    cyc(0,1,0,3,9,0,0,1, 8'd2,0,0);
    // Down wrap from 2 by 4 -> 8; reload 2; saturate down -> 0, then hold at 0.
    cyc(1,0,0,4,9,0,0,0, 8'd8,1,1);
    cyc(1,0,1,4,9,1,2,0, 8'd2,0,1);
    cyc(1,0,1,4,9,0,0,0, 8'd0,1,1);
    cyc(1,0,1,4,9,0,0,0, 8'd0,1,1);
    cyc(0,0,1,4,9,0,0,0, 8'd0,0,1);
    cyc(0,0,1,4,9,0,0,1, 8'd0,0,0);
    // Load priority and out-of-range recovery.
    cyc(1,1,0,1,9,1,200,0, 8'd200,0,0);
    cyc(1,1,0,1,9,0,0,0,   8'd0,1,1);
    cyc(1,1,0,1,9,1,200,0, 8'd200,0,1);
    cyc(1,0,0,1,9,0,0,0,   8'd9,1,1);
    // Flag race: event + clear same cycle keeps flag; clear alone drops it.
    cyc(0,0,0,1,9,0,0,1, 8'd9,0,0);
    cyc(1,1,0,1,9,0,0,1, 8'd0,1,1);
    cyc(0,1,0,1,9,0,0,1, 8'd0,0,0);
    // Step=0 holds; ordinary up step without event.
    cyc(1,1,0,0,9,0,0,0, 8'd0,0,0);
    cyc(1,1,0,2,9,0,0,0, 8'd2,0,0);
    // Limit=0: out-of-range snap, then every step is an event at 0.
    cyc(1,1,0,1,0,0,0,0, 8'd0,1,1);
    cyc(1,1,0,3,0,0,0,0, 8'd0,1,1);
    cyc(1,0,1,2,0,0,0,0, 8'd0,1,1);
    cyc(0,0,0,2,0,0,0,1, 8'd0,0,0);
    // Full-width arithmetic near 2^WIDTH.
    cyc(0,1,0,15,255,1,250,0, 8'd250,0,0);
    cyc(1,1,0,15,255,0,0,0,   8'd9,1,1);
    cyc(1,1,1,15,255,1,250,0, 8'd250,0,1);
    cyc(1,1,1,15,255,0,0,0,   8'd255,1,1);
    cyc(1,1,1,1,255,0,0,0,    8'd255,1,1);
    cyc(1,1,0,1,255,0,0,0,    8'd0,1,1);
    cyc(1,0,0,5,255,1,3,0,    8'd3,0,1);
    cyc(1,0,0,5,255,0,0,0,    8'd254,1,1);
    cyc(1,0,0,4,255,0,0,0,    8'd250,0,1);
    // Lowered limit snaps down to Limit; Step == Limit+1 wraps to same value.
    cyc(1,0,0,15,14,0,0,0,    8'd14,1,1);
    cyc(1,1,0,15,14,0,0,0,    8'd14,1,1);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
